// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the MM:SS clock: controller state encoding, BCD field
// widths and the two-digit modulo-60 BCD increment used by both the
// time-setting controller and the seconds counter.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int BCD_W   = 4;          // one BCD digit
  localparam int FIELD_W = 2 * BCD_W;  // one MM or SS field (tens + ones)

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2
  } clk_state_e;

  // Two-digit BCD increment that wraps 59 -> 00. Any malformed field
  // (digit above 9 or tens above 5) is forced to 00 so that a corrupt value
  // captured from the counter is repaired by the first increment.
  function automatic logic [FIELD_W-1:0] bcd_inc59(input logic [FIELD_W-1:0] i_val);
    logic [BCD_W-1:0]   w_tens;
    logic [BCD_W-1:0]   w_ones;
    logic [FIELD_W-1:0] w_res;
    w_tens = i_val[FIELD_W-1:BCD_W];
    w_ones = i_val[BCD_W-1:0];
    if ((w_tens > 4'd5) || (w_ones > 4'd9)) begin
      w_res = 8'h00;
    end else if (w_ones == 4'd9) begin
      if (w_tens == 4'd5) begin
        w_res = 8'h00;
      end else begin
        w_res = {w_tens + 4'd1, 4'd0};
      end
    end else begin
      w_res = {w_tens, w_ones + 4'd1};
    end
    return w_res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low push-button, debounces it and emits a single
// one-cycle pulse each time the accepted level goes from released to pressed.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   key_n  in   raw button, active-low, asynchronous to clk
//   press  out  registered one-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;    // accepted (debounced) level, 1 = released
  logic             r_level_d;  // accepted level one cycle earlier
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser, stability counter and press-edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      // The counter only runs while the synchronised level disagrees with
      // the accepted one; any bounce back to the accepted level restarts it.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_level_d <= r_level;
      // Only the released->pressed transition produces a pulse.
      r_press   <= r_level_d & ~r_level;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller for the MM:SS clock. Debounces the mode and
// increment buttons and walks RUN -> SET_MIN -> SET_SEC -> RUN. While setting,
// the counter is frozen and the edited value is displayed with the field being
// edited blinking; leaving SET_SEC with mode reloads the counter. An idle
// timeout in either set state abandons the edit without reloading.
//
// Ports:
//   clk         in   25 MHz system clock
//   rst         in   synchronous reset, active-high
//   key_mode    in   raw mode button, active-low, asynchronous
//   key_inc     in   raw increment button, active-low, asynchronous
//   cur_num     in   live BCD time {min_tens, min_ones, sec_tens, sec_ones}
//   run_en      out  counter count enable
//   load        out  one-cycle pulse, counter takes load_num
//   load_num    out  BCD value to load
//   disp_num    out  BCD value to the display driver
//   blink_mask  out  1 = blank digit; bit3 = min_tens ... bit0 = sec_ones
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES     = 500000,
  parameter int BLINK_CYCLES   = 6250000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic [15:0] cur_num,
  output logic        run_en,
  output logic        load,
  output logic [15:0] load_num,
  output logic [15:0] disp_num,
  output logic [3:0]  blink_mask
);

  localparam int              BLK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
  localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             w_mode_press;
  logic             w_inc_press;
  logic             w_inc_eff;
  logic             w_timeout;
  logic             w_state_chg;

  clk_state_e       r_state;
  clk_state_e       w_state_nxt;
  logic [15:0]      r_edit;
  logic [15:0]      w_edit_nxt;
  logic             w_load_nxt;
  logic [15:0]      w_load_num_nxt;
  logic [15:0]      w_disp_nxt;
  logic [3:0]       w_mask_nxt;

  logic [BLK_W-1:0] r_blink_cnt;
  logic [BLK_W-1:0] w_blink_cnt_nxt;
  logic             r_blink_phase;
  logic             w_blink_phase_nxt;
  logic [TMO_W-1:0] r_idle_cnt;
  logic [TMO_W-1:0] w_idle_cnt_nxt;

  logic             r_run_en;
  logic             r_load;
  logic [15:0]      r_load_num;
  logic [15:0]      r_disp_num;
  logic [3:0]       r_blink_mask;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_mode),
    .press (w_mode_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_inc),
    .press (w_inc_press)
  );

  // Mode has priority: a coincident increment is dropped.
  assign w_inc_eff = w_inc_press & ~w_mode_press;
  assign w_timeout = (r_state != RUN) && (r_idle_cnt == TMO_LAST);

  // Next state, edit value and load request.
  always_comb begin
    w_state_nxt = r_state;
    w_edit_nxt  = r_edit;
    w_load_nxt  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mode_press) begin
          w_state_nxt = SET_MIN;
          w_edit_nxt  = cur_num;
        end else begin
          w_state_nxt = RUN;
        end
      end
      SET_MIN: begin
        if (w_mode_press) begin
          w_state_nxt = SET_SEC;
        end else if (w_inc_eff) begin
          w_edit_nxt = {bcd_inc59(r_edit[15:8]), r_edit[7:0]};
        end else if (w_timeout) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = SET_MIN;
        end
      end
      SET_SEC: begin
        if (w_mode_press) begin
          w_state_nxt = RUN;
          w_load_nxt  = 1'b1;
        end else if (w_inc_eff) begin
          w_edit_nxt = {r_edit[15:8], bcd_inc59(r_edit[7:0])};
        end else if (w_timeout) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = SET_SEC;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // Idle timer and blink phase generator.
  always_comb begin
    w_idle_cnt_nxt    = r_idle_cnt;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;

    if (w_state_chg || w_mode_press || w_inc_press) begin
      w_idle_cnt_nxt = '0;
    end else if (r_state != RUN) begin
      w_idle_cnt_nxt = r_idle_cnt + TMO_W'(1);
    end else begin
      w_idle_cnt_nxt = '0;
    end

    // Entering a state or bumping a value restarts the blink with the digits
    // visible, so the user always sees the new value immediately.
    if (w_state_chg || w_inc_press || (r_state == RUN)) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
    end else if (r_blink_cnt == BLK_LAST) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = ~r_blink_phase;
    end else begin
      w_blink_cnt_nxt   = r_blink_cnt + BLK_W'(1);
      w_blink_phase_nxt = r_blink_phase;
    end
  end

  // Output values, derived from the next state so they change together.
  always_comb begin
    w_load_num_nxt = r_load_num;
    w_disp_nxt     = w_edit_nxt;
    w_mask_nxt     = 4'b0000;

    if (w_load_nxt) begin
      w_load_num_nxt = r_edit;
    end else begin
      w_load_num_nxt = r_load_num;
    end

    if (w_state_nxt == RUN) begin
      w_disp_nxt = cur_num;
    end else begin
      w_disp_nxt = w_edit_nxt;
    end

    case (w_state_nxt)
      SET_MIN: w_mask_nxt = w_blink_phase_nxt ? 4'b1100 : 4'b0000;
      SET_SEC: w_mask_nxt = w_blink_phase_nxt ? 4'b0011 : 4'b0000;
      default: w_mask_nxt = 4'b0000;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_edit        <= 16'h0000;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_idle_cnt    <= '0;
      r_run_en      <= 1'b1;
      r_load        <= 1'b0;
      r_load_num    <= 16'h0000;
      r_disp_num    <= 16'h0000;
      r_blink_mask  <= 4'b0000;
    end else begin
      r_state       <= w_state_nxt;
      r_edit        <= w_edit_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_run_en      <= (w_state_nxt == RUN);
      r_load        <= w_load_nxt;
      r_load_num    <= w_load_num_nxt;
      r_disp_num    <= w_disp_nxt;
      r_blink_mask  <= w_mask_nxt;
    end
  end

  assign run_en     = r_run_en;
  assign load       = r_load;
  assign load_num   = r_load_num;
  assign disp_num   = r_disp_num;
  assign blink_mask = r_blink_mask;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode;
  logic        key_inc;
  logic [15:0] cur_num;
  logic        run_en;
  logic        load;
  logic [15:0] load_num;
  logic [15:0] disp_num;
  logic [3:0]  blink_mask;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          load_cnt = 0;
  int          mode_press_cnt = 0;
  int          inc_press_cnt = 0;
  logic [15:0] load_num_cap = 16'h0000;
  logic        load_run_en_cap = 1'b0;

  clock_set_ctrl #(
    .DEB_CYCLES     (4),
    .BLINK_CYCLES   (8),
    .TIMEOUT_CYCLES (64)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .cur_num    (cur_num),
    .run_en     (run_en),
    .load       (load),
    .load_num   (load_num),
    .disp_num   (disp_num),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  // Event monitor: load pulses and internal press pulses
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt        <= load_cnt + 1;
      load_num_cap    <= load_num;
      load_run_en_cap <= run_en;
    end
    if (u_dut.w_mode_press === 1'b1) mode_press_cnt <= mode_press_cnt + 1;
    if (u_dut.w_inc_press === 1'b1) inc_press_cnt <= inc_press_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] num);
    cur_num  = num;
    key_mode = 1'b1;
    key_inc  = 1'b1;
    rst      = 1'b1;
    tick(2);
    rst      = 1'b0;
  endtask

  // Press one or both keys; returns at the sample after the state reacted.
  task automatic press(input logic use_mode, input logic use_inc, input string tag);
    bit seen;
    seen = 1'b0;
    tick(8);
    key_mode = ~use_mode;
    key_inc  = ~use_inc;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (use_mode ? (u_dut.w_mode_press === 1'b1) : (u_dut.w_inc_press === 1'b1)) seen = 1'b1;
    end
    key_mode = 1'b1;
    key_inc  = 1'b1;
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL %s_press_seen: got 0 want 1", tag); end
    tick(1);
  endtask

  task automatic test_reset;
    int base;
    do_reset(16'h1234);
    base = load_cnt;
    n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL reset_run_en: got %b want 1", run_en); end
    n_cmp++; if (load !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %b want 0", load); end
    n_cmp++; if (load_num !== 16'h0000) begin n_bad++; $display("FAIL reset_load_num: got %h want 0000", load_num); end
    n_cmp++; if (disp_num !== 16'h0000) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", disp_num); end
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_mask: got %b want 0000", blink_mask); end
    tick(1);
    n_cmp++; if (disp_num !== 16'h1234) begin n_bad++; $display("FAIL run_disp_latency: got %h want 1234", disp_num); end
    tick(10);
    n_cmp++; if (load_cnt - base !== 0) begin n_bad++; $display("FAIL idle_no_load: got %0d want 0", load_cnt - base); end
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL idle_mask: got %b want 0000", blink_mask); end
  endtask

  task automatic test_debounce;
    int base;
    int first;
    do_reset(16'h1234);
    tick(2);
    base = inc_press_cnt;
    key_inc = 1'b0;
    tick(3);
    key_inc = 1'b1;
    tick(10);
    n_cmp++; if (inc_press_cnt - base !== 0) begin n_bad++; $display("FAIL glitch_no_press: got %0d want 0", inc_press_cnt - base); end
    n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL glitch_run_en: got %b want 1", run_en); end
    base  = mode_press_cnt;
    first = -1;
    key_mode = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if ((u_dut.w_mode_press === 1'b1) && (first < 0)) first = k;
    end
    key_mode = 1'b1;
    tick(10);
    n_cmp++; if (first !== 7) begin n_bad++; $display("FAIL press_latency: got %0d want 7", first); end
    n_cmp++; if (mode_press_cnt - base !== 1) begin n_bad++; $display("FAIL held_one_press: got %0d want 1", mode_press_cnt - base); end
    n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL set_min_run_en: got %b want 0", run_en); end
    n_cmp++; if (disp_num !== 16'h1234) begin n_bad++; $display("FAIL set_min_disp: got %h want 1234", disp_num); end
  endtask

  task automatic test_edit;
    int base;
    do_reset(16'h5958);
    base = load_cnt;
    press(1'b1, 1'b0, "edit_mode1");
    n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL edit_run_en1: got %b want 0", run_en); end
    n_cmp++; if (disp_num !== 16'h5958) begin n_bad++; $display("FAIL edit_capture: got %h want 5958", disp_num); end
    press(1'b0, 1'b1, "edit_inc1");
    n_cmp++; if (disp_num !== 16'h0058) begin n_bad++; $display("FAIL edit_min_wrap: got %h want 0058", disp_num); end
    press(1'b1, 1'b0, "edit_mode2");
    n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL edit_run_en2: got %b want 0", run_en); end
    press(1'b0, 1'b1, "edit_inc2");
    n_cmp++; if (disp_num !== 16'h0059) begin n_bad++; $display("FAIL edit_sec_inc: got %h want 0059", disp_num); end
    n_cmp++; if (load_cnt - base !== 0) begin n_bad++; $display("FAIL edit_no_early_load: got %0d want 0", load_cnt - base); end
    press(1'b1, 1'b0, "edit_mode3");
    n_cmp++; if (load !== 1'b1) begin n_bad++; $display("FAIL load_pulse: got %b want 1", load); end
    tick(1);
    n_cmp++; if (load !== 1'b0) begin n_bad++; $display("FAIL load_one_cycle: got %b want 0", load); end
    n_cmp++; if (load_cnt - base !== 1) begin n_bad++; $display("FAIL load_count: got %0d want 1", load_cnt - base); end
    n_cmp++; if (load_num_cap !== 16'h0059) begin n_bad++; $display("FAIL load_num: got %h want 0059", load_num_cap); end
    n_cmp++; if (load_run_en_cap !== 1'b1) begin n_bad++; $display("FAIL load_run_en: got %b want 1", load_run_en_cap); end
    n_cmp++; if (disp_num !== 16'h5958) begin n_bad++; $display("FAIL run_disp_after_load: got %h want 5958", disp_num); end
  endtask

  task automatic test_blink;
    do_reset(16'h1234);
    press(1'b1, 1'b0, "blink_mode");
    tick(4);
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL blink_k4: got %b want 0000", blink_mask); end
    tick(4);
    n_cmp++; if (blink_mask !== 4'b1100) begin n_bad++; $display("FAIL blink_k8: got %b want 1100", blink_mask); end
    tick(7);
    n_cmp++; if (blink_mask !== 4'b1100) begin n_bad++; $display("FAIL blink_k15: got %b want 1100", blink_mask); end
    tick(1);
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL blink_k16: got %b want 0000", blink_mask); end
    press(1'b0, 1'b1, "blink_inc");
    n_cmp++; if (disp_num !== 16'h1334) begin n_bad++; $display("FAIL blink_inc_value: got %h want 1334", disp_num); end
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL blink_inc_k0: got %b want 0000", blink_mask); end
    tick(7);
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL blink_inc_k7: got %b want 0000", blink_mask); end
    tick(1);
    n_cmp++; if (blink_mask !== 4'b1100) begin n_bad++; $display("FAIL blink_inc_k8: got %b want 1100", blink_mask); end
  endtask

  task automatic test_timeout;
    int base;
    do_reset(16'h1234);
    base = load_cnt;
    press(1'b1, 1'b0, "tmo_mode1");
    press(1'b1, 1'b0, "tmo_mode2");
    tick(8);
    n_cmp++; if (blink_mask !== 4'b0011) begin n_bad++; $display("FAIL sec_blink: got %b want 0011", blink_mask); end
    tick(55);
    n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", run_en); end
    tick(1);
    n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL tmo_return: got %b want 1", run_en); end
    n_cmp++; if (load_cnt - base !== 0) begin n_bad++; $display("FAIL tmo_no_load: got %0d want 0", load_cnt - base); end
    n_cmp++; if (disp_num !== 16'h1234) begin n_bad++; $display("FAIL tmo_disp: got %h want 1234", disp_num); end
    cur_num = 16'h0042;
    tick(1);
    n_cmp++; if (disp_num !== 16'h0042) begin n_bad++; $display("FAIL tmo_track: got %h want 0042", disp_num); end
  endtask

  task automatic test_fields;
    do_reset(16'h0919);
    press(1'b1, 1'b0, "carry_mode1");
    press(1'b0, 1'b1, "carry_inc1");
    n_cmp++; if (disp_num !== 16'h1019) begin n_bad++; $display("FAIL min_carry: got %h want 1019", disp_num); end
    press(1'b1, 1'b0, "carry_mode2");
    press(1'b0, 1'b1, "carry_inc2");
    n_cmp++; if (disp_num !== 16'h1020) begin n_bad++; $display("FAIL sec_carry: got %h want 1020", disp_num); end
    do_reset(16'h7A3F);
    press(1'b1, 1'b0, "bad_mode1");
    n_cmp++; if (disp_num !== 16'h7A3F) begin n_bad++; $display("FAIL bad_capture: got %h want 7a3f", disp_num); end
    press(1'b0, 1'b1, "bad_inc1");
    n_cmp++; if (disp_num !== 16'h003F) begin n_bad++; $display("FAIL bad_min_fix: got %h want 003f", disp_num); end
    press(1'b1, 1'b0, "bad_mode2");
    press(1'b0, 1'b1, "bad_inc2");
    n_cmp++; if (disp_num !== 16'h0000) begin n_bad++; $display("FAIL bad_sec_fix: got %h want 0000", disp_num); end
  endtask

  task automatic test_simul_and_reset;
    int base;
    do_reset(16'h2345);
    base = load_cnt;
    press(1'b1, 1'b0, "sim_mode1");
    press(1'b1, 1'b1, "sim_both");
    n_cmp++; if (disp_num !== 16'h2345) begin n_bad++; $display("FAIL simul_min_kept: got %h want 2345", disp_num); end
    tick(8);
    n_cmp++; if (blink_mask !== 4'b0011) begin n_bad++; $display("FAIL simul_in_sec: got %b want 0011", blink_mask); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL mid_rst_run_en: got %b want 1", run_en); end
    n_cmp++; if (disp_num !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_disp: got %h want 0000", disp_num); end
    n_cmp++; if (blink_mask !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_mask: got %b want 0000", blink_mask); end
    n_cmp++; if (load_num !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_load_num: got %h want 0000", load_num); end
    tick(3);
    n_cmp++; if (load_cnt - base !== 0) begin n_bad++; $display("FAIL mid_rst_no_load: got %0d want 0", load_cnt - base); end
    n_cmp++; if (disp_num !== 16'h2345) begin n_bad++; $display("FAIL mid_rst_track: got %h want 2345", disp_num); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_edit();
    test_blink();
    test_timeout();
    test_fields();
    test_simul_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
